hilo_unit: RTL
==============

Name: hilo_unit

Overview:
Parametrised HI/LO register unit that replaces the two-way combinational HI select with a registered, multi-source, arbitrated write path. Any of N_SRC result producers (multiplier, divider, move-to-HI/LO, spares) commit into the HI and LO registers through a valid/ready handshake. A pending-operation counter gives the control unit an interlock, so HI/LO reads stall while a long-latency operation is still in flight. Sits between the mult/div units and the register-file write-back mux.

Parameters:
WIDTH, 32, data width of HI, LO and every source bus
N_SRC, 4, number of producer channels (0 = mult, 1 = div, 2 = mthi/mtlo, 3 = spare)
MAX_PEND, 2, maximum number of in-flight tracked operations
TRACK_MASK, 4'b0011, bit i = 1 means a commit from source i retires one pending operation
BYPASS, 0, 1 = hi_out/lo_out forward the value being committed in the same cycle

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  synchronous, active-low reset
src_valid  in  N_SRC  per-source commit request
src_ready  out  N_SRC  per-source grant (combinational)
src_hi  in  N_SRC*WIDTH  HI data; source i occupies bits [i*WIDTH +: WIDTH]
src_lo  in  N_SRC*WIDTH  LO data, same packing as src_hi
src_hi_we  in  N_SRC  source i writes HI when it commits
src_lo_we  in  N_SRC  source i writes LO when it commits
op_start  in  1  a tracked operation has been issued (one-cycle pulse)
start_ready  out  1  op_start is accepted this cycle
hi_out  out  WIDTH  current HI value
lo_out  out  WIDTH  current LO value
hilo_busy  out  1  one or more tracked operations are pending
err_underflow  out  1  sticky: a tracked commit arrived with the counter at 0

Behaviour:
- Reset: when reset_n = 0 at a rising clk edge, hi_q = 0, lo_q = 0, pend_cnt = 0, err_underflow = 0. Reset overrides every simultaneous commit or start. Consequently hi_out = 0, lo_out = 0, hilo_busy = 0 and start_ready = 1 after reset.
- Arbitration: fixed priority, lowest index wins. src_ready[i] = src_valid[i] AND no src_valid[j] for any j < i. At most one ready bit is high per cycle.
- Non-granted sources must hold valid and data stable until granted; they take no timeout.
- Commit: on a clock edge where source g is granted:
  - hi_q <= src_hi[g] if src_hi_we[g] = 1
  - lo_q <= src_lo[g] if src_lo_we[g] = 1
  - A register whose write-enable is 0 keeps its value.
  - A grant with both write-enables at 0 is legal: nothing is written, but the commit still counts for pending tracking.
- Latency: the committed value appears on hi_out/lo_out the cycle after the grant when BYPASS = 0. When BYPASS = 1, hi_out/lo_out show the committing value combinationally during the grant cycle.
- Pending counter: pend_cnt is clog2(MAX_PEND+1) bits wide.
  - start_ready = (pend_cnt < MAX_PEND). Accepted start = op_start AND start_ready. An op_start with start_ready = 0 is ignored; the issuer must hold it.
  - A tracked commit is a grant from source g with TRACK_MASK[g] = 1.
  - Next value:
    - accepted start and no tracked commit: increment
    - tracked commit and no accepted start, with pend_cnt > 0: decrement
    - both in the same cycle: unchanged; this is legal even when pend_cnt = 0
    - tracked commit with pend_cnt = 0 and no accepted start: no change, err_underflow <= 1
- err_underflow stays set until reset.
- hilo_busy = (pend_cnt != 0). The control FSM stalls mfhi/mflo while hilo_busy = 1.
- The HI/LO write path never blocks a source for capacity reasons; only arbitration delays a commit.
- Reset mid-operation: the pending count is discarded. A late commit from the aborted operation sets err_underflow; the control unit must also reset the mult/div units.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles while src_valid = 4'b0011 -> hi_out = 0, lo_out = 0, hilo_busy = 0, err_underflow = 0, start_ready = 1.
- Single commit: src_valid[0] = 1, src_hi = 32'hDEAD_BEEF, src_lo = 32'h0000_1234, both write-enables = 1 -> src_ready = 4'b0001; next cycle hi_out = DEADBEEF, lo_out = 00001234. With BYPASS = 1, the same values appear in the grant cycle.
- Contention: src_valid = 4'b0110 (div and mthi) -> div granted first, mthi granted the following cycle; final HI = mthi data, LO = div LO (mthi has lo_we = 0).
- Interlock: op_start twice -> pend_cnt = 2, start_ready = 0, a third op_start is ignored; one mult commit -> hilo_busy = 1, start_ready = 1; div commit -> hilo_busy = 0.
- Simultaneous start and commit, with pend_cnt = 1 and with pend_cnt = 0 -> count unchanged in both cases, err_underflow = 0.
- Underflow and reset: mult commit with pend_cnt = 0 -> err_underflow = 1, HI/LO still written; then reset_n low for one cycle -> err_underflow = 0, hi_out = 0.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO register unit: fixed-priority arbitrated commit path from N_SRC producers
// plus a pending-operation counter that interlocks HI/LO reads.
module hilo_unit #(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      N_SRC      = 4,
   parameter int unsigned      MAX_PEND   = 2,
   parameter logic [N_SRC-1:0] TRACK_MASK = 4'b0011,
   parameter bit               BYPASS     = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_SRC-1:0]       src_valid,
   output logic [N_SRC-1:0]       src_ready,
   input  logic [N_SRC*WIDTH-1:0] src_hi,
   input  logic [N_SRC*WIDTH-1:0] src_lo,
   input  logic [N_SRC-1:0]       src_hi_we,
   input  logic [N_SRC-1:0]       src_lo_we,
   input  logic                   op_start,
   output logic                   start_ready,
   output logic [WIDTH-1:0]       hi_out,
   output logic [WIDTH-1:0]       lo_out,
   output logic                   hilo_busy,
   output logic                   err_underflow
);

   localparam int unsigned CW = $clog2(MAX_PEND + 1);

   logic [CW-1:0]    pend_cnt;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] gnt_hi, gnt_lo;
   logic             gnt_hwe, gnt_lwe, gnt_trk;
   logic             blocked;
   logic             start_acc;

   // Lowest-index requester wins; everything above it is blocked.
   always_comb begin
      src_ready = '0;
      blocked   = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (src_valid[i] && !blocked) src_ready[i] = 1'b1;
         blocked = blocked | src_valid[i];
      end
   end

   // Mux out the granted source's payload (src_ready is one-hot or zero).
   always_comb begin
      gnt_hi  = '0;
      gnt_lo  = '0;
      gnt_hwe = 1'b0;
      gnt_lwe = 1'b0;
      gnt_trk = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (src_ready[i]) begin
            gnt_hi  = src_hi[i*WIDTH +: WIDTH];
            gnt_lo  = src_lo[i*WIDTH +: WIDTH];
            gnt_hwe = src_hi_we[i];
            gnt_lwe = src_lo_we[i];
            gnt_trk = TRACK_MASK[i];
         end
      end
   end

   assign start_ready = (pend_cnt < CW'(MAX_PEND));
   assign start_acc   = op_start & start_ready;
   assign hilo_busy   = (pend_cnt != '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hi_q          <= '0;
         lo_q          <= '0;
         pend_cnt      <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (gnt_hwe) hi_q <= gnt_hi;
         if (gnt_lwe) lo_q <= gnt_lo;
         // A start and a tracked commit in the same cycle cancel, even at zero.
         if (start_acc && !gnt_trk) begin
            pend_cnt <= pend_cnt + CW'(1);
         end else if (gnt_trk && !start_acc) begin
            if (pend_cnt != '0) pend_cnt <= pend_cnt - CW'(1);
            else                err_underflow <= 1'b1;
         end
      end
   end

   always_comb begin
      hi_out = hi_q;
      lo_out = lo_q;
      if (BYPASS) begin
         if (gnt_hwe) hi_out = gnt_hi;
         if (gnt_lwe) lo_out = gnt_lo;
      end
   end

endmodule
